const_loader: RTL and testbench
===============================

Name: const_loader

Overview:
- Sequencer that reads the constant ROM (`const`) and copies selected constants into the main register RAM.
- Takes a 5-bit load mask and a RAM base address. For each set bit, in ascending order, it issues the ROM's one-hot address, waits out the ROM's registered latency, checks `effective`, and writes the 198-bit value to RAM at base+index.
- Sits between the top-level controller and the ROM/RAM write port. It initialises 0, 1, +, - and the cubic constant before a pairing run.

Parameters:
- WIDTH, 198, data width of a constant and of a RAM word.
- RAM_AW, 6, RAM address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin a load; sampled only when busy=0
- mask  input  5  bit i selects constant i (0:zero, 1:one, 2:plus, 3:minus, 4:cubic)
- base  input  RAM_AW  RAM address of constant 0
- const_addr  output  6  ROM address; one-hot 1<<i while reading, else 0
- const_out  input  WIDTH  ROM data; valid one cycle after const_addr is sampled by the ROM
- const_effective  input  1  ROM valid flag, aligned with const_out
- ram_we  output  1  one-cycle write strobe
- ram_waddr  output  RAM_AW  write address
- ram_wdata  output  WIDTH  write data
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at end of load
- error  output  1  sticky: a selected read returned effective=0; cleared on next accepted start

Behaviour:
- Reset state: all outputs are registered and reset to 0; state=IDLE; idx=0.
- Reset mid-operation: aborts immediately, with no further writes or done pulse.
- State IDLE:
  - On start=1: latch mask and base, set idx<=0, busy<=1, error<=0, go to SCAN.
  - start while busy=1 is ignored and does not affect the latched mask/base.
- State SCAN:
  - idx==5: done<=1 for one cycle, busy<=0, go to IDLE.
  - else if mask_q[idx]=1: const_addr<=1<<idx, go to WAIT.
  - else: idx<=idx+1, stay in SCAN. A skipped bit costs exactly one cycle.
- State WAIT: hold const_addr while the ROM registers its output; go to CAPTURE.
- State CAPTURE (ROM data valid this cycle):
  - If const_effective=1: ram_we<=1, ram_waddr<=base_q+idx, ram_wdata<=const_out.
  - Otherwise: error<=1 and no write.
  - In both cases: const_addr<=0, idx<=idx+1, go to SCAN.
- Write strobe: ram_we is high for exactly one cycle per written constant. ram_waddr and ram_wdata are held until the next write; they are don't-care when ram_we=0.
- Address arithmetic: base_q+idx is modulo 2^RAM_AW, so base=62 with idx=3 gives address 1.
- Latency: with start sampled at edge E0, done is high after edge E(6+2*popcount(mask)).
  - Write k (k-th set bit) has ram_we high after edge E(3+idx_k+2*(k-1)).
- Empty mask: no ROM access, no writes, done after E6.
- Back-to-back loads: start may be asserted in the cycle done is high. busy is already 0 then, so the new load is accepted.
- Only the one-hot addresses 1, 2, 4, 8 and 16 are ever driven on const_addr; never 32 and never multiple bits.

Test Plan:
- reset, then mask=5'b00001, base=10 -> const_addr=1 after E1; ram_we after E3 with waddr=10, wdata=0; done after E8; error=0.
- mask=5'b11111, base=0, real const module -> five writes: addr0=0, addr1=1, addr2={6'b000101,192'd0}, addr3={6'b001001,192'd0}, addr4={6'b010101,192'd0}; done after E16; busy low after.
- mask=0 -> no ram_we and const_addr stays 0 throughout; done after E6.
- ROM stub forces effective=0 for addr 4, mask=5'b00110 -> one write (waddr=base+1) only; error=1 and stays 1 after done; next start clears it.
- base=63, mask=5'b00011 -> writes at 63 then 0 (wrap).
- reset asserted after E2 of a mask=5'b11111 load -> all outputs 0 next cycle, no further writes or done pulse. start pulsed while busy -> ignored, with no change to the write sequence.

Source files
------------

// File: rtl/const_loader.sv
// Constant loader: walks a 5-bit mask, reads each selected constant from the
// registered constant ROM and writes it into the register RAM at base+index.
module const_loader #(
  parameter int WIDTH  = 198,
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        mask,
  input  logic [RAM_AW-1:0] base,
  output logic [5:0]        const_addr,
  input  logic [WIDTH-1:0]  const_out,
  input  logic              const_effective,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT,
    CAPTURE
  } state_t;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic [2:0]        idx_d;
  logic [4:0]        mask_q;
  logic [RAM_AW-1:0] base_q;
  logic [RAM_AW-1:0] waddr_d;
  logic [5:0]        const_addr_q;
  logic              ram_we_q;
  logic [RAM_AW-1:0] ram_waddr_q;
  logic [WIDTH-1:0]  ram_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  // The write address wraps modulo 2^RAM_AW by construction of the adder width.
  assign idx_d   = idx_q + 3'd1;
  assign waddr_d = base_q + RAM_AW'(idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mask_q       <= '0;
      base_q       <= '0;
      const_addr_q <= '0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q  <= mask;
            base_q  <= base;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (idx_q == 3'd5) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (mask_q[idx_q]) begin
            const_addr_q <= 6'd1 << idx_q;
            state_q      <= WAIT;
          end else begin
            idx_q <= idx_d;
          end
        end
        WAIT: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          // An ineffective read is flagged but never written, so RAM keeps its old word.
          if (const_effective) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= waddr_d;
            ram_wdata_q <= const_out;
          end else begin
            error_q <= 1'b1;
          end
          const_addr_q <= '0;
          idx_q        <= idx_d;
          state_q      <= SCAN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign const_addr = const_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_const_loader.sv
// Bench for const_loader: registered ROM stub with an injectable bad entry and
// a cycle-timeline reference model derived from mask, base and the constant table.
module tb_const_loader;

  localparam int WIDTH  = 198;
  localparam int RAM_AW = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic [4:0]        mask;
  logic [RAM_AW-1:0] base;
  logic [5:0]        const_addr;
  logic [WIDTH-1:0]  const_out;
  logic              const_effective;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              busy;
  logic              done;
  logic              error;

  int errCount;
  int checkCount;
  int romBad;

  logic [WIDTH-1:0]  consts   [0:4];
  logic [5:0]        expAddr  [0:63];
  logic              expWe    [0:63];
  logic [RAM_AW-1:0] expWaddr [0:63];
  logic [WIDTH-1:0]  expWdata [0:63];

  const_loader #(.WIDTH(WIDTH), .RAM_AW(RAM_AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mask            (mask),
    .base            (base),
    .const_addr      (const_addr),
    .const_out       (const_out),
    .const_effective (const_effective),
    .ram_we          (ram_we),
    .ram_waddr       (ram_waddr),
    .ram_wdata       (ram_wdata),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data and effective flag appear one cycle after the address.
  always @(posedge clk) begin
    case (const_addr)
      6'd1:    const_out <= consts[0];
      6'd2:    const_out <= consts[1];
      6'd4:    const_out <= consts[2];
      6'd8:    const_out <= consts[3];
      6'd16:   const_out <= consts[4];
      default: const_out <= '0;
    endcase
    const_effective <= (const_addr inside {6'd1, 6'd2, 6'd4, 6'd8, 6'd16}) &&
                       !(romBad >= 0 && const_addr == 6'(1 << romBad));
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_const_addr"}, WIDTH'(const_addr), '0);
    checkOutput({tag, "_ram_we"},     WIDTH'(ram_we), '0);
    checkOutput({tag, "_ram_waddr"},  WIDTH'(ram_waddr), '0);
    checkOutput({tag, "_ram_wdata"},  ram_wdata, '0);
    checkOutput({tag, "_busy"},       WIDTH'(busy), '0);
    checkOutput({tag, "_done"},       WIDTH'(done), '0);
    checkOutput({tag, "_error"},      WIDTH'(error), '0);
  endtask

  // Drive one load (called just after a clock edge) and check every cycle up to done.
  task automatic applyStimulus(input logic [4:0] m, input logic [RAM_AW-1:0] b,
                               input int badIdx, input bit junkStart);
    int k;
    int s;
    int expDone;
    bit expErr;
    for (int c = 0; c < 64; c++) begin
      expAddr[c] = '0;
      expWe[c]   = 1'b0;
      expWaddr[c] = '0;
      expWdata[c] = '0;
    end
    k = 0;
    expErr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        s = 1 + i + 2 * k;
        expAddr[s]     = 6'(1 << i);
        expAddr[s + 1] = 6'(1 << i);
        if (i == badIdx) begin
          expErr = 1'b1;
        end else begin
          expWe[s + 2]    = 1'b1;
          expWaddr[s + 2] = RAM_AW'((int'(b) + i) % (1 << RAM_AW));
          expWdata[s + 2] = consts[i];
        end
        k++;
      end
    end
    expDone = 6 + 2 * k;
    romBad = badIdx;

    start = 1'b1;
    mask  = m;
    base  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = 5'($urandom);
    base  = RAM_AW'($urandom);
    for (int cyc = 1; cyc <= expDone; cyc++) begin
      if (junkStart && cyc == 2) begin
        start = 1'b1;
        mask  = ~m;
        base  = b + 6'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("c%0d_const_addr", cyc), WIDTH'(const_addr), WIDTH'(expAddr[cyc]));
      checkOutput($sformatf("c%0d_ram_we", cyc), WIDTH'(ram_we), WIDTH'(expWe[cyc]));
      if (expWe[cyc]) begin
        checkOutput($sformatf("c%0d_ram_waddr", cyc), WIDTH'(ram_waddr), WIDTH'(expWaddr[cyc]));
        checkOutput($sformatf("c%0d_ram_wdata", cyc), ram_wdata, expWdata[cyc]);
      end
      checkOutput($sformatf("c%0d_busy", cyc), WIDTH'(busy), WIDTH'(cyc < expDone));
      checkOutput($sformatf("c%0d_done", cyc), WIDTH'(done), WIDTH'(cyc == expDone));
      if (cyc == 1) checkOutput("error_cleared", WIDTH'(error), '0);
      if (cyc == expDone) checkOutput("error_at_done", WIDTH'(error), WIDTH'(expErr));
    end
    start = 1'b0;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    romBad     = -1;
    consts[0]  = '0;
    consts[1]  = WIDTH'(1);
    consts[2]  = {6'b000101, 192'd0};
    consts[3]  = {6'b001001, 192'd0};
    consts[4]  = {6'b010101, 192'd0};
    reset = 1'b1;
    start = 1'b0;
    mask  = '0;
    base  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(5'b00001, 6'd10, -1, 1'b0);
    applyStimulus(5'b11111, 6'd0,  -1, 1'b0);
    applyStimulus(5'b00000, 6'd20, -1, 1'b0);
    applyStimulus(5'b00110, 6'd30,  2, 1'b0);
    checkOutput("error_sticky", WIDTH'(error), WIDTH'(1));
    @(posedge clk);
    #1;
    checkOutput("error_sticky_idle", WIDTH'(error), WIDTH'(1));
    applyStimulus(5'b00011, 6'd63, -1, 1'b0);
    applyStimulus(5'b10101, 6'd5,  -1, 1'b1);

    // Reset after E2 of a full load: everything clears and stays quiet.
    start = 1'b1;
    mask  = 5'b11111;
    base  = 6'd40;
    romBad = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkIdleOutputs("midreset");
    begin
      bit quiet;
      quiet = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (ram_we || done || busy || const_addr != 6'd0) quiet = 1'b0;
      end
      checkOutput("midreset_quiet", WIDTH'(quiet), WIDTH'(1));
    end

    for (int n = 0; n < 30; n++) begin
      int bad;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(5'($urandom), RAM_AW'($urandom), bad, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
